crc_three_arbiter: RTL and testbench

CRC_THREE_ARBITER -- requirements
Module: crc_three_arbiter

---
 rtl/crc_three_arbiter.sv | 115 +++++++++++
 tb/tb_crc_three_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/crc_three_arbiter.sv
// Two-requester round-robin front end sharing one 3-bit parity encoder.
// Each 9-bit payload is encoded one chunk per cycle into a 12-bit codeword.

module crc_three (
  input  logic [2:0] d,
  output logic [3:0] code
);
  assign code = {d, ^d};
endmodule

// state | meaning
// IDLE  | waiting for a request; arbitrates and captures payload
// ENC2  | encode payload[8:6] into o_code[11:8]; ack to winner
// ENC1  | encode payload[5:3] into o_code[7:4]
// ENC0  | encode payload[2:0] into o_code[3:0]
// DONE  | codeword complete; o_valid pulse
module crc_three_arbiter (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0,
  input  logic [8:0]  i_data0,
  output logic        o_ack0,
  input  logic        i_req1,
  input  logic [8:0]  i_data1,
  output logic        o_ack1,
  output logic        o_valid,
  output logic [11:0] o_code,
  output logic        o_src,
  output logic        o_busy
);

  typedef enum logic [2:0] {IDLE, ENC2, ENC1, ENC0, DONE} state_t;

  state_t      state_q, state_d;
  logic        src_q;
  logic        prio_q;
  logic        out_src_q;
  logic [8:0]  payload_q;
  logic [11:0] code_q;
  logic        any_req;
  logic        win;
  logic [2:0]  enc_in;
  logic [3:0]  enc_out;

  assign any_req = i_req0 | i_req1;
  // prio_q names the requester that wins a tie
  assign win     = (i_req0 & i_req1) ? prio_q : i_req1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ENC2;
      ENC2:    state_d = ENC1;
      ENC1:    state_d = ENC0;
      ENC0:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    enc_in = 3'd0;
    case (state_q)
      ENC2:    enc_in = payload_q[8:6];
      ENC1:    enc_in = payload_q[5:3];
      ENC0:    enc_in = payload_q[2:0];
      default: enc_in = 3'd0;
    endcase
  end

  crc_three u_crc_three (
    .d    (enc_in),
    .code (enc_out)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      src_q     <= 1'b0;
      prio_q    <= 1'b0;
      out_src_q <= 1'b0;
      payload_q <= 9'd0;
      code_q    <= 12'h000;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            src_q     <= win;
            payload_q <= win ? i_data1 : i_data0;
            prio_q    <= ~win;
          end
        end
        ENC2: code_q[11:8] <= enc_out;
        ENC1: code_q[7:4]  <= enc_out;
        ENC0: begin
          code_q[3:0] <= enc_out;
          out_src_q   <= src_q;
        end
        default: ;
      endcase
    end
  end

  assign o_ack0  = (state_q == ENC2) & ~src_q;
  assign o_ack1  = (state_q == ENC2) &  src_q;
  assign o_valid = (state_q == DONE);
  assign o_busy  = (state_q != IDLE);
  assign o_code  = code_q;
  assign o_src   = out_src_q;

endmodule

// File: tb/tb_crc_three_arbiter.sv
// Directed and randomized bench for crc_three_arbiter against a
// transaction-level model of arbitration and codeword construction.

module tb_crc_three_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req0 = 1'b0;
  logic [8:0]  i_data0 = 9'd0;
  logic        o_ack0;
  logic        i_req1 = 1'b0;
  logic [8:0]  i_data1 = 9'd0;
  logic        o_ack1;
  logic        o_valid;
  logic [11:0] o_code;
  logic        o_src;
  logic        o_busy;

  int n_checks = 0;
  int n_pass   = 0;
  int model_prio = 0;

  always #5 i_clk = ~i_clk;

  crc_three_arbiter dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req0  (i_req0),
    .i_data0 (i_data0),
    .o_ack0  (o_ack0),
    .i_req1  (i_req1),
    .i_data1 (i_data1),
    .o_ack1  (o_ack1),
    .o_valid (o_valid),
    .o_code  (o_code),
    .o_src   (o_src),
    .o_busy  (o_busy)
  );

  function automatic logic [31:0] ref_code(input logic [8:0] d);
    int code = 0;
    for (int i = 0; i < 3; i++) begin
      int chunk = (int'(d) / (1 << (3 * i))) % 8;
      int par   = $countones(chunk) % 2;
      code += (chunk * 2 + par) * (1 << (4 * i));
    end
    return code;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ack0"},  o_ack0, 0);
    check({tag, "_ack1"},  o_ack1, 0);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_busy"},  o_busy, 0);
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge of the
  // first idle cycle after the codeword.
  task automatic do_txn(input bit r0, input bit r1, input logic [8:0] d0,
                        input logic [8:0] d1, input bit hold, input bit corrupt);
    int winner;
    logic [8:0] exp_payload;
    i_req0 = r0; i_req1 = r1; i_data0 = d0; i_data1 = d1;
    winner = (r0 && r1) ? model_prio : (r1 ? 1 : 0);
    exp_payload = (winner == 1) ? d1 : d0;
    @(negedge i_clk);
    check("ack0", o_ack0, (winner == 0) ? 1 : 0);
    check("ack1", o_ack1, (winner == 1) ? 1 : 0);
    check("busy_enc2", o_busy, 1);
    check("valid_enc2", o_valid, 0);
    model_prio = 1 - winner;
    if (!hold) begin
      i_req0 = 1'b0; i_req1 = 1'b0;
    end
    @(negedge i_clk);
    if (corrupt) begin
      i_data0 = ~d0; i_data1 = ~d1;
    end
    check("ack_enc1", {o_ack0, o_ack1}, 0);
    check("valid_enc1", o_valid, 0);
    @(negedge i_clk);
    check("valid_enc0", o_valid, 0);
    @(negedge i_clk);
    check("valid_done", o_valid, 1);
    check("ack_done", {o_ack0, o_ack1}, 0);
    check("code", o_code, ref_code(exp_payload));
    check("src", o_src, winner);
    @(negedge i_clk);
    check("valid_after", o_valid, 0);
    check("code_hold", o_code, ref_code(exp_payload));
    if (!hold) check("busy_after", o_busy, 0);
  endtask

  initial begin
    // reset state
    #12;
    check_idle_outputs("rst");
    check("rst_code", o_code, 0);
    check("rst_src", o_src, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    // no requests for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      check_idle_outputs("quiet");
      check("quiet_code", o_code, 0);
    end

    do_txn(1, 0, 9'b101_110_011, 9'd0, 0, 0);
    check("ex_aC6", o_code, 12'hAC6);
    do_txn(0, 1, 9'd0, 9'b111_001_000, 0, 0);
    check("ex_F30", o_code, 12'hF30);
    do_txn(1, 0, 9'h15A, 9'h0, 0, 1);

    // both requesters held from reset: 0,1,0,1
    i_rst_n = 1'b0;
    i_req0 = 1'b1; i_req1 = 1'b1;
    model_prio = 0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      do_txn(1, 1, 9'h0A5 + 9'(t), 9'h13C - 9'(t), 1, 0);
      check("rr_order", o_src, t % 2);
    end
    i_req0 = 1'b0; i_req1 = 1'b0;
    @(negedge i_clk);

    // reset during ENC1 with both requests pending
    i_req0 = 1'b1; i_req1 = 1'b1; i_data0 = 9'h1C7; i_data1 = 9'h038;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    check("abort_code", o_code, 0);
    check("abort_src", o_src, 0);
    @(negedge i_clk);
    check("abort_valid", o_valid, 0);
    model_prio = 0;
    i_rst_n = 1'b1;
    do_txn(1, 1, 9'h1C7, 9'h038, 0, 0);
    check("reserve_src0", o_src, 0);

    // randomized traffic
    for (int n = 0; n < 16; n++) begin
      bit r0, r1, cor;
      logic [8:0] d0, d1;
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      d0 = 9'($urandom);
      d1 = 9'($urandom);
      cor = 1'($urandom_range(0, 1));
      do_txn(r0, r1, d0, d1, 0, cor);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
